// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 matrix scan, single-key debounce and key-code encode with a
//            one-clock valid strobe toward the downstream FIFO writer.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    input  logic       full,
    output logic [3:0] col,
    output logic       v,
    output logic [3:0] code,
    output logic       overrun
);

    localparam logic [7:0] c_DWELL_LAST = 8'(SCAN_DIV - 1);
    localparam logic [3:0] c_COUNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SCAN         = 2'd0,
        S_DEBOUNCE     = 2'd1,
        S_EMIT         = 2'd2,
        S_WAIT_RELEASE = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_sync1;
    logic [3:0] r_rs;
    logic [7:0] r_dwell;
    logic [3:0] r_col;
    logic [1:0] r_col_idx;
    logic [3:0] r_pattern;
    logic [1:0] r_row_idx;
    logic [3:0] r_match;
    logic [3:0] r_release;
    logic       r_v;
    logic [3:0] r_code;
    logic       r_overrun;

    logic       w_sample;
    logic       w_one_hot;
    logic [1:0] w_row_enc;

    assign w_sample  = (r_dwell == c_DWELL_LAST);
    assign w_one_hot = (r_pattern != 4'd0) && ((r_pattern & (r_pattern - 4'd1)) == 4'd0);

    always_comb begin
        w_row_enc = 2'd0;
        if (r_rs[3])      w_row_enc = 2'd3;
        else if (r_rs[2]) w_row_enc = 2'd2;
        else if (r_rs[1]) w_row_enc = 2'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_SCAN;
            r_sync1   <= 4'd0;
            r_rs      <= 4'd0;
            r_dwell   <= 8'd0;
            r_col     <= 4'b0001;
            r_col_idx <= 2'd0;
            r_pattern <= 4'd0;
            r_row_idx <= 2'd0;
            r_match   <= 4'd0;
            r_release <= 4'd0;
            r_v       <= 1'b0;
            r_code    <= 4'd0;
            r_overrun <= 1'b0;
        end else begin
            r_sync1 <= row;
            r_rs    <= r_sync1;

            // Every state change except EMIT->WAIT_RELEASE lands on a sample,
            // so a free-running dwell counter restarts exactly on those entries.
            r_dwell <= w_sample ? 8'd0 : r_dwell + 8'd1;

            r_v       <= 1'b0;
            r_overrun <= 1'b0;

            case (r_state)
                S_SCAN: begin
                    if (w_sample) begin
                        if (r_rs != 4'd0) begin
                            r_pattern <= r_rs;
                            r_row_idx <= w_row_enc;
                            r_match   <= 4'd0;
                            r_state   <= S_DEBOUNCE;
                        end else begin
                            r_col     <= {r_col[2:0], r_col[3]};
                            r_col_idx <= r_col_idx + 2'd1;
                        end
                    end
                end

                S_DEBOUNCE: begin
                    if (w_sample) begin
                        if (r_rs != r_pattern) begin
                            r_state   <= S_SCAN;
                            r_col     <= {r_col[2:0], r_col[3]};
                            r_col_idx <= r_col_idx + 2'd1;
                        end else if (w_one_hot) begin
                            // Multi-row patterns never count, so they park here until released.
                            if (r_match == c_COUNT_LAST) begin
                                r_state <= S_EMIT;
                                if (full) begin
                                    r_overrun <= 1'b1;
                                end else begin
                                    r_v    <= 1'b1;
                                    r_code <= {r_row_idx, r_col_idx};
                                end
                            end else begin
                                r_match <= r_match + 4'd1;
                            end
                        end
                    end
                end

                S_EMIT: begin
                    r_release <= 4'd0;
                    r_state   <= S_WAIT_RELEASE;
                end

                S_WAIT_RELEASE: begin
                    if (w_sample) begin
                        if (r_rs != 4'd0) begin
                            r_release <= 4'd0;
                        end else if (r_release == c_COUNT_LAST) begin
                            r_state   <= S_SCAN;
                            r_col     <= {r_col[2:0], r_col[3]};
                            r_col_idx <= r_col_idx + 2'd1;
                        end else begin
                            r_release <= r_release + 4'd1;
                        end
                    end
                end

                default: r_state <= S_SCAN;
            endcase
        end
    end

    assign col     = r_col;
    assign v       = r_v;
    assign code    = r_code;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Self-checking bench for keypad_scanner using a timeline model of
//            scan, debounce, emit and release events.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       full  = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic       v;
    logic [3:0] code;
    logic       overrun;

    logic       key_on   = 1'b0;
    logic [1:0] key_c    = 2'd0;
    logic [3:0] key_mask = 4'd0;

    int         cyc;
    int         v_seen  = 0;
    int         ov_seen = 0;
    int         checks  = 0;
    int         errors  = 0;
    int         anchor_cyc = 0;
    int         anchor_idx = 0;
    logic [3:0] exp_code   = 4'd0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)) dut (
        .clock   (clock),
        .reset   (reset),
        .row     (row),
        .full    (full),
        .col     (col),
        .v       (v),
        .code    (code),
        .overrun (overrun)
    );

    always #5 clock = ~clock;

    // Physical matrix: pressed keys of column key_c pull their rows high while driven.
    assign row = (key_on && col[key_c]) ? key_mask : 4'd0;

    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(posedge clock) begin
        if (v)       v_seen  <= v_seen + 1;
        if (overrun) ov_seen <= ov_seen + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic int idle_idx(input int n);
        return (anchor_idx + (n - anchor_cyc) / SD) % 4;
    endfunction

    function automatic int ceil_sd(input int x);
        return ((x + SD - 1) / SD) * SD;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        return 4'(1 << i);
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // kind 0: valid press held `param` clocks past the strobe
    // kind 1: release so the `param`-th debounce sample sees no key
    // kind 2: multi-row pattern released `param` clocks after detection
    task automatic run_scenario(input int kind, input int r, input int c,
                                input logic [3:0] mask, input int param, input logic full_val);
        int e0, c0, t, vt, rn, x, n;
        logic [3:0] ec;
        logic ev, eo;
        full = full_val;
        while (cyc % SD != 0) begin
            tick();
            ec = onehot(idle_idx(cyc));
            checks++;
            if (col !== ec) begin
                errors++;
                $display("FAIL align_col cyc=%0d got=%b exp=%b", cyc, col, ec);
            end
        end
        e0 = cyc;
        c0 = idle_idx(e0);
        t  = e0 + SD * (((c - c0 + 4) % 4) + 1);
        key_c    = 2'(c);
        key_mask = mask;
        key_on   = 1'b1;
        case (kind)
            0: begin vt = t + DC * SD; rn = vt + param; x = ceil_sd(rn + 3) + (DC - 1) * SD; end
            1: begin vt = -1; rn = t + (param - 1) * SD; x = t + param * SD; end
            default: begin vt = -1; rn = t + param; x = ceil_sd(rn + 3); end
        endcase
        while (cyc < x + SD) begin
            tick();
            n = cyc;
            if (n == rn) key_on = 1'b0;
            if (n == vt && !full_val) exp_code = 4'(4 * r + c);
            if (n < t)      ec = onehot(idle_idx(n));
            else if (n < x) ec = onehot(c);
            else            ec = onehot((c + 1 + (n - x) / SD) % 4);
            ev = (n == vt) && !full_val;
            eo = (n == vt) && full_val;
            checks++;
            if (col !== ec) begin
                errors++;
                $display("FAIL scn_col kind=%0d cyc=%0d got=%b exp=%b", kind, n, col, ec);
            end
            checks++;
            if (v !== ev) begin
                errors++;
                $display("FAIL scn_v kind=%0d cyc=%0d got=%b exp=%b", kind, n, v, ev);
            end
            checks++;
            if (overrun !== eo) begin
                errors++;
                $display("FAIL scn_overrun kind=%0d cyc=%0d got=%b exp=%b", kind, n, overrun, eo);
            end
            checks++;
            if (code !== exp_code) begin
                errors++;
                $display("FAIL scn_code kind=%0d cyc=%0d got=%0d exp=%0d", kind, n, code, exp_code);
            end
        end
        key_on     = 1'b0;
        anchor_cyc = x;
        anchor_idx = (c + 1) % 4;
    endtask

    task automatic test_reset;
        logic [3:0] ec;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (col !== 4'b0001) begin errors++; $display("FAIL reset_col got=%b exp=0001", col); end
        checks++;
        if (v !== 1'b0) begin errors++; $display("FAIL reset_v got=%b exp=0", v); end
        checks++;
        if (code !== 4'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", code); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            ec = onehot((i / SD) % 4);
            checks++;
            if (col !== ec) begin errors++; $display("FAIL rotate_col cyc=%0d got=%b exp=%b", i, col, ec); end
            checks++;
            if (v !== 1'b0) begin errors++; $display("FAIL rotate_v cyc=%0d got=%b exp=0", i, v); end
        end
        anchor_cyc = 0;
        anchor_idx = 0;
        exp_code   = 4'd0;
    endtask

    task automatic test_single_press;
        int v0, o0;
        v0 = v_seen; o0 = ov_seen;
        run_scenario(0, 1, 2, 4'b0010, 170, 1'b0);
        checks++;
        if (v_seen - v0 !== 1) begin errors++; $display("FAIL press_vcount got=%0d exp=1", v_seen - v0); end
        checks++;
        if (ov_seen - o0 !== 0) begin errors++; $display("FAIL press_ovcount got=%0d exp=0", ov_seen - o0); end
        checks++;
        if (code !== 4'd6) begin errors++; $display("FAIL press_code got=%0d exp=6", code); end
    endtask

    task automatic test_debounce_abort;
        int v0;
        v0 = v_seen;
        run_scenario(1, 0, 3, 4'b0001, 2, 1'b0);
        checks++;
        if (v_seen - v0 !== 0) begin errors++; $display("FAIL abort_vcount got=%0d exp=0", v_seen - v0); end
        checks++;
        if (code !== 4'd6) begin errors++; $display("FAIL abort_code got=%0d exp=6", code); end
    endtask

    task automatic test_multi_key;
        int v0, o0;
        v0 = v_seen; o0 = ov_seen;
        run_scenario(2, 0, 0, 4'b0011, 60, 1'b0);
        checks++;
        if (v_seen - v0 !== 0) begin errors++; $display("FAIL multi_vcount got=%0d exp=0", v_seen - v0); end
        checks++;
        if (ov_seen - o0 !== 0) begin errors++; $display("FAIL multi_ovcount got=%0d exp=0", ov_seen - o0); end
    endtask

    task automatic test_overrun;
        int v0, o0;
        v0 = v_seen; o0 = ov_seen;
        run_scenario(0, 3, 3, 4'b1000, 5, 1'b1);
        checks++;
        if (ov_seen - o0 !== 1) begin errors++; $display("FAIL ovr_ovcount got=%0d exp=1", ov_seen - o0); end
        checks++;
        if (v_seen - v0 !== 0) begin errors++; $display("FAIL ovr_vcount got=%0d exp=0", v_seen - v0); end
        checks++;
        if (code !== 4'd6) begin errors++; $display("FAIL ovr_code_kept got=%0d exp=6", code); end
        v0 = v_seen;
        run_scenario(0, 3, 3, 4'b1000, 5, 1'b0);
        checks++;
        if (v_seen - v0 !== 1) begin errors++; $display("FAIL ovr_retry_vcount got=%0d exp=1", v_seen - v0); end
        checks++;
        if (code !== 4'd15) begin errors++; $display("FAIL ovr_retry_code got=%0d exp=15", code); end
    endtask

    task automatic test_reset_mid_debounce;
        int t, c0, v0;
        logic [3:0] ec;
        while (cyc % SD != 0) tick();
        c0 = idle_idx(cyc);
        t  = cyc + SD * (((1 - c0 + 4) % 4) + 1);
        key_c = 2'd1; key_mask = 4'b0100; key_on = 1'b1;
        while (cyc < t + SD + 2) tick();
        checks++;
        if (col !== 4'b0010) begin errors++; $display("FAIL mid_frozen_col got=%b exp=0010", col); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (col !== 4'b0001) begin errors++; $display("FAIL mid_reset_col got=%b exp=0001", col); end
        checks++;
        if (v !== 1'b0) begin errors++; $display("FAIL mid_reset_v got=%b exp=0", v); end
        checks++;
        if (code !== 4'd0) begin errors++; $display("FAIL mid_reset_code got=%0d exp=0", code); end
        key_on = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        anchor_cyc = 0; anchor_idx = 0; exp_code = 4'd0;
        v0 = v_seen;
        for (int i = 0; i < 40; i++) begin
            tick();
            ec = onehot(idle_idx(cyc));
            checks++;
            if (col !== ec) begin errors++; $display("FAIL mid_idle_col cyc=%0d got=%b exp=%b", cyc, col, ec); end
        end
        checks++;
        if (v_seen - v0 !== 0) begin errors++; $display("FAIL mid_stale_v got=%0d exp=0", v_seen - v0); end
        run_scenario(0, 2, 1, 4'b0100, 10, 1'b0);
        checks++;
        if (code !== 4'd9) begin errors++; $display("FAIL mid_redetect_code got=%0d exp=9", code); end
    endtask

    task automatic test_random;
        int kind, r, c, param, v0, o0, ev, eo;
        logic [3:0] mask, pc, want;
        logic fv;
        for (int i = 0; i < 14; i++) begin
            kind = $urandom_range(0, 2);
            r    = $urandom_range(0, 3);
            c    = $urandom_range(0, 3);
            fv   = (kind == 0) && ($urandom_range(0, 2) == 0);
            if (kind == 2) begin
                mask = 4'($urandom_range(3, 15));
                while ($countones(mask) < 2) mask = 4'($urandom_range(3, 15));
                param = $urandom_range(0, 40);
            end else begin
                mask  = onehot(r);
                param = (kind == 0) ? $urandom_range(1, 40) : $urandom_range(1, DC);
            end
            v0 = v_seen; o0 = ov_seen; pc = exp_code;
            run_scenario(kind, r, c, mask, param, fv);
            ev   = (kind == 0 && !fv) ? 1 : 0;
            eo   = (kind == 0 && fv) ? 1 : 0;
            want = (kind == 0 && !fv) ? 4'(4 * r + c) : pc;
            checks++;
            if (v_seen - v0 !== ev) begin errors++; $display("FAIL rnd_vcount it=%0d got=%0d exp=%0d", i, v_seen - v0, ev); end
            checks++;
            if (ov_seen - o0 !== eo) begin errors++; $display("FAIL rnd_ovcount it=%0d got=%0d exp=%0d", i, ov_seen - o0, eo); end
            checks++;
            if (code !== want) begin errors++; $display("FAIL rnd_code it=%0d got=%0d exp=%0d", i, code, want); end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_debounce_abort();
        test_multi_key();
        test_overrun();
        test_reset_mid_debounce();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Front-end stage of the keypad path. It drives the 4x4 matrix columns, samples the rows, debounces a single key, and encodes it to a 4-bit key code. It then emits a one-cycle `v` strobe with `code` stable, and the downstream FIFO write controller consumes that strobe. Only one key is reported per press; ghost and multi-key patterns are rejected.

## Interface
- `SCAN_DIV`, default 4: clocks each column is driven (dwell). Legal range 3..255, so the synchronised rows settle before sampling.
- `DEBOUNCE_CYCLES`, default 4: consecutive matching samples required for press confirmation and for release confirmation. Legal range 1..15.
- `clock` input, 1 bit: single system clock, all logic on posedge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `row` input, 4 bits: matrix rows, active-high for a pressed key in the driven column. Asynchronous to `clock`.
- `full` input, 1 bit: downstream FIFO full.
- `col` output, 4 bits: one-hot active-high column drive.
- `v` output, 1 bit: key-valid strobe, exactly one clock wide per accepted press.
- `code` output, 4 bits: key code, equal to 4*row_index + col_index. Holds its value until the next `v`.
- `overrun` output, 1 bit: one-clock pulse when a confirmed key is dropped because `full`=1.

## Operation
- `row` passes through a 2-flop synchroniser. All decisions use the synchronised value `rs`.
- A dwell counter counts 0..SCAN_DIV-1. A *sample* is taken on the clock where the counter = SCAN_DIV-1, after which the counter wraps to 0.
- The state machine has four states: SCAN, DEBOUNCE, EMIT, WAIT_RELEASE. All registered outputs are listed below.
- SCAN:
  - `col` rotates 0001 -> 0010 -> 0100 -> 1000 -> 0001, one step per sample.
  - At a sample with `rs`≠0: latch `rs` as the pattern and the current column index, freeze `col`, clear the match count, and go to DEBOUNCE.
- DEBOUNCE:
  - `col` is held.
  - At each sample, if `rs` equals the pattern, increment the match count; when the count reaches DEBOUNCE_CYCLES, go to EMIT.
  - At any sample where `rs` differs, return to SCAN and advance `col` to the next column.
  - A latched pattern that is not one-hot (two or more rows) never goes to EMIT. It waits in DEBOUNCE until the pattern changes, then returns to SCAN with no strobe.
- EMIT lasts exactly one clock.
  - If `full`=0: `v`=1 and `code` is updated to 4*row_index + col_index.
  - If `full`=1: `v`=0, `overrun`=1, and `code` is unchanged.
  - The next state is always WAIT_RELEASE.
- WAIT_RELEASE:
  - `col` is held.
  - Each sample with `rs`=0 increments the release count; any nonzero sample clears it.
  - When the count reaches DEBOUNCE_CYCLES, go to SCAN and advance `col` to the next column.
  - A held key therefore never repeats.
- The dwell counter restarts at 0 on every state entry except EMIT→WAIT_RELEASE. Across that transition it continues counting.

## Timing
- Reset values, asserted asynchronously and immediately on `reset`=0:
  - `col`=0001, `v`=0, `code`=0000, `overrun`=0.
  - State SCAN; dwell, match, and release counters at 0; synchroniser flops at 0.
- Reset mid-operation discards any pending key. No `v` is produced for that key after `reset` is released.
- First `col` step occurs SCAN_DIV clocks after reset is released.
- Row-to-decision latency is 2 clocks (synchroniser).
- Press latency: let the detection sample occur at edge T. Then:
  - the DEBOUNCE→EMIT transition happens at edge T + DEBOUNCE_CYCLES*SCAN_DIV;
  - `v` is high for the following single clock.
- `v` and `overrun` are mutually exclusive and never high for two consecutive clocks.
- `full` is sampled only in the EMIT clock.
- `code` changes only on the edge that raises `v`.

## Test plan
Defaults apply (SCAN_DIV=4, DEBOUNCE_CYCLES=4).
1. Reset, no keys -> `col`=0001 with `v`=0 and `code`=0. `col`=0010 after 4 clocks, 1000 after 12, and back to 0001 at 16.
2. `row[1]` high only while `col[2]`=1, held for 200 clocks -> exactly one `v` pulse. `code`=6. `v` appears 16 clocks after the detection sample. `col` stays 0100 until 4 clean release samples, then advances to 1000.
3. Key row0/col3 with `rs` dropping to 0 at the 2nd debounce sample -> no `v`. Scanning resumes with `col`=0001 on the next step.
4. `row`=0011 in column 0 (two keys) held -> no `v` and no `overrun`. Releasing the keys returns the block to SCAN.
5. Valid press of row3/col3 with `full`=1 during EMIT -> `v`=0, `overrun`=1 for one clock, and `code` keeps its previous value. A second press with `full`=0 gives `v`=1 and `code`=15.
6. `reset` pulsed low during DEBOUNCE -> `col`=0001 and `v`=0 immediately. No `v` occurs for the interrupted press unless it is re-detected and fully debounced.
